// File: rtl/mat_res_axil_reader.sv
// Result-matrix sink: captures one ROWS x COLS result on a valid/ready handshake and
// serves it, plus status and a capture counter, over an AXI4-Lite read-only slave.
module mat_res_axil_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] c [0:ROWS-1][0:COLS-1],
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  buf_full,
    output logic [31:0]           cap_count
);

    localparam int                NUM_ELEM    = ROWS * COLS;
    localparam int                WORD_W      = ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] WORD_STATUS = WORD_W'(0);
    localparam logic [WORD_W-1:0] WORD_CAPCNT = WORD_W'(1);
    localparam logic [WORD_W-1:0] WORD_ELEM   = WORD_W'(32'h100 >> 2);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_buf [0:NUM_ELEM-1];
    logic                  r_full;
    logic                  r_release;
    logic [31:0]           r_cap_count;
    logic [31:0]           r_rdata;
    logic [1:0]            r_rresp;

    logic [WORD_W-1:0]     w_word;
    logic [WORD_W-1:0]     w_elem_off;
    logic                  w_is_elem;
    logic [DATA_WIDTH-1:0] w_elem_data;
    logic [31:0]           w_rd_data;
    logic [1:0]            w_rd_resp;
    logic                  w_rd_release;
    logic                  w_ar_hs;
    logic                  w_r_hs;
    logic                  w_capture;
    logic                  w_unused_addr_lsb;

    // Byte-lane bits carry no meaning for a 32-bit register file.
    assign w_unused_addr_lsb = ^s_araddr[1:0];

    assign w_word     = s_araddr[ADDR_WIDTH-1:2];
    assign w_elem_off = w_word - WORD_ELEM;
    assign w_is_elem  = (w_word >= WORD_ELEM) && (w_elem_off < WORD_W'(NUM_ELEM));

    assign s_arready = (r_state == ST_IDLE);
    assign s_rvalid  = (r_state == ST_RESP);
    assign s_rdata   = r_rdata;
    assign s_rresp   = r_rresp;
    assign buf_full  = r_full;
    assign in_ready  = ~r_full;
    assign cap_count = r_cap_count;

    assign w_ar_hs   = s_arvalid & s_arready;
    assign w_r_hs    = s_rvalid & s_rready;
    assign w_capture = in_valid & ~r_full;

    always_comb begin
        w_elem_data = '0;
        for (int k = 0; k < NUM_ELEM; k++) begin
            if (w_elem_off == WORD_W'(k)) begin
                w_elem_data = r_buf[k];
            end
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_rd_data    = '0;
        w_rd_resp    = RESP_SLVERR;
        w_rd_release = 1'b0;
        if (w_word == WORD_STATUS) begin
            w_rd_data = {30'd0, in_valid, r_full};
            w_rd_resp = RESP_OKAY;
        end else if (w_word == WORD_CAPCNT) begin
            w_rd_data = r_cap_count;
            w_rd_resp = RESP_OKAY;
        end else if (w_is_elem && r_full) begin
            w_rd_data    = 32'(w_elem_data);
            w_rd_resp    = RESP_OKAY;
            w_rd_release = (w_elem_off == WORD_W'(NUM_ELEM - 1));
        end
    end

    // ST_INIT keeps s_arready low for the first cycle out of reset.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_INIT: w_state_nxt = ST_IDLE;
            ST_IDLE: if (s_arvalid) w_state_nxt = ST_RESP;
            ST_RESP: if (s_rready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_release <= 1'b0;
        end else if (w_ar_hs) begin
            r_rdata   <= w_rd_data;
            r_rresp   <= w_rd_resp;
            r_release <= w_rd_release;
        end
    end

    // NOTE: the buffer is reset because a reset must leave no stale result visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full      <= 1'b0;
            r_cap_count <= '0;
            for (int k = 0; k < NUM_ELEM; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            if (w_capture) begin
                r_full      <= 1'b1;
                r_cap_count <= r_cap_count + 32'd1;
                for (int i = 0; i < ROWS; i++) begin
                    for (int j = 0; j < COLS; j++) begin
                        r_buf[i*COLS+j] <= c[i][j];
                    end
                end
            end else if (w_r_hs && r_release) begin
                r_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mat_res_axil_reader.sv
// Self-checking bench for mat_res_axil_reader: directed vector table, multi-cycle
// corner sequences and randomized traffic against a simple behavioural model.
module tb_mat_res_axil_reader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] c [0:3][0:3];
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic        buf_full;
    logic [31:0] cap_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model: the buffered matrix, its full flag and the capture count.
    logic [31:0] mdl_buf [16];
    bit          mdl_full  = 1'b0;
    logic [31:0] mdl_count = '0;

    typedef struct {
        string       name;
        logic [11:0] addr;
        int          delay;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        bit          exp_full;
    } vec_t;

    vec_t tbl [13];

    mat_res_axil_reader #(
        .DATA_WIDTH(32), .ROWS(4), .COLS(4), .ADDR_WIDTH(12)
    ) dut (
        .clk(clk), .rstn(rstn), .c(c), .in_valid(in_valid), .in_ready(in_ready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .buf_full(buf_full), .cap_count(cap_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic mdl_reset();
        mdl_full  = 1'b0;
        mdl_count = '0;
        for (int k = 0; k < 16; k++) mdl_buf[k] = '0;
    endtask

    // What software should see for a read of addr given the model state right now.
    task automatic mdl_read(input logic [11:0] addr, output logic [31:0] d,
                            output logic [1:0] r, output bit rel);
        int idx;
        d = '0; r = 2'b10; rel = 1'b0;
        if (addr / 4 == 0) begin
            d = {30'd0, in_valid, mdl_full}; r = 2'b00;
        end else if (addr / 4 == 1) begin
            d = mdl_count; r = 2'b00;
        end else if (addr >= 12'h100 && addr < 12'h140 && mdl_full) begin
            idx = (int'(addr) - 'h100) / 4;
            d = mdl_buf[idx]; r = 2'b00; rel = (idx == 15);
        end
    endtask

    // Called and returning on a negedge; in_valid pulse lasts one full clock.
    task automatic pulse_capture();
        in_valid = 1'b1;
        if (!mdl_full) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) mdl_buf[i*4+j] = c[i][j];
            mdl_full  = 1'b1;
            mdl_count = mdl_count + 1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("cap_full", buf_full, mdl_full);
        check("cap_in_ready", in_ready, !mdl_full);
        check("cap_count", cap_count, mdl_count);
    endtask

    task automatic do_read(input string name, input logic [11:0] addr, input int delay,
                           input logic [31:0] exp_d, input logic [1:0] exp_r,
                           input bit exp_full_after);
        int  n;
        bit  full_before;
        n = 0;
        full_before = buf_full;
        while (!s_arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_arready"}, s_arready, 1);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        s_araddr  = $urandom_range(0, 4095);
        check({name, "_rvalid"}, s_rvalid, 1);
        check({name, "_rdata"}, s_rdata, exp_d);
        check({name, "_rresp"}, s_rresp, exp_r);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check({name, "_hold_rvalid"}, s_rvalid, 1);
            check({name, "_hold_arready"}, s_arready, 0);
            check({name, "_hold_rdata"}, s_rdata, exp_d);
            check({name, "_hold_full"}, buf_full, full_before);
        end
        s_rready = 1'b1;
        @(negedge clk);
        s_rready = 1'b0;
        check({name, "_full_after"}, buf_full, exp_full_after);
        check({name, "_in_ready_after"}, in_ready, !exp_full_after);
    endtask

    task automatic rand_read(input logic [11:0] addr);
        logic [31:0] ed;
        logic [1:0]  er;
        bit          rel;
        mdl_read(addr, ed, er, rel);
        if (rel) mdl_full = 1'b0;
        do_read("rnd", addr, $urandom_range(0, 2), ed, er, mdl_full);
    endtask

    initial begin
        tbl[0]  = '{"e00",      12'h100, 0, 32'd1,  2'b00, 1'b1};
        tbl[1]  = '{"e11",      12'h114, 0, 32'd6,  2'b00, 1'b1};
        tbl[2]  = '{"e32",      12'h138, 0, 32'd15, 2'b00, 1'b1};
        tbl[3]  = '{"capcnt1",  12'h004, 0, 32'd1,  2'b00, 1'b1};
        tbl[4]  = '{"status_f", 12'h000, 0, 32'd1,  2'b00, 1'b1};
        tbl[5]  = '{"e00_lsb",  12'h103, 0, 32'd1,  2'b00, 1'b1};
        tbl[6]  = '{"below",    12'h0FC, 0, 32'd0,  2'b10, 1'b1};
        tbl[7]  = '{"above",    12'h200, 0, 32'd0,  2'b10, 1'b1};
        tbl[8]  = '{"e01_hold", 12'h104, 5, 32'd2,  2'b00, 1'b1};
        tbl[9]  = '{"last",     12'h13C, 0, 32'd16, 2'b00, 1'b0};
        tbl[10] = '{"last_emp", 12'h13C, 0, 32'd0,  2'b10, 1'b0};
        tbl[11] = '{"status_e", 12'h000, 0, 32'd0,  2'b00, 1'b0};
        tbl[12] = '{"capcnt1b", 12'h004, 0, 32'd1,  2'b00, 1'b0};

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) c[i][j] = '0;
        mdl_reset();

        // Reset values while rstn is held low.
        #3;
        check("rst_arready", s_arready, 0);
        check("rst_rvalid", s_rvalid, 0);
        check("rst_rdata", s_rdata, 0);
        check("rst_rresp", s_rresp, 0);
        check("rst_full", buf_full, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_cap_count", cap_count, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        do_read("status0", 12'h000, 0, 32'd0, 2'b00, 1'b0);
        check("cap_count0", cap_count, 0);

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) c[i][j] = i * 4 + j + 1;
        pulse_capture();

        // A second matrix offered while full must be ignored; in_valid shows in STATUS.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) c[i][j] = 32'hDEAD_0000 + i * 4 + j;
        in_valid = 1'b1;
        do_read("status_iv", 12'h000, 0, 32'd3, 2'b00, 1'b1);
        do_read("e00_iv", 12'h100, 0, 32'd1, 2'b00, 1'b1);
        in_valid = 1'b0;
        check("no_cap_while_full", cap_count, 1);

        for (int t = 0; t < 13; t++) begin
            do_read(tbl[t].name, tbl[t].addr, tbl[t].delay,
                    tbl[t].exp_data, tbl[t].exp_resp, tbl[t].exp_full);
        end
        mdl_full = 1'b0;

        // Randomized traffic checked against the model.
        for (int it = 0; it < 200; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++) c[i][j] = $urandom;
                    pulse_capture();
                end
                1: rand_read(12'(12'h100 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3)));
                2: rand_read(12'h13C);
                default: begin
                    case ($urandom_range(0, 2))
                        0: rand_read(12'h000);
                        1: rand_read(12'h004);
                        default: rand_read(12'($urandom_range(0, 4095)));
                    endcase
                end
            endcase
        end
        check("rnd_cap_count", cap_count, mdl_count);

        // Reset in the middle of a pending response with the buffer full.
        if (!mdl_full) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) c[i][j] = $urandom;
            pulse_capture();
        end
        s_araddr  = 12'h104;
        s_arvalid = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0;
        check("mid_rvalid", s_rvalid, 1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_rvalid", s_rvalid, 0);
        check("mid_rst_full", buf_full, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_rdata", s_rdata, 0);
        check("mid_rst_cap_count", cap_count, 0);
        mdl_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) c[i][j] = $urandom;
            pulse_capture();
            do_read("drain", 12'h13C, 0, c[3][3], 2'b00, 1'b0);
            mdl_full = 1'b0;
        end
        check("cap_count3", cap_count, 3);
        do_read("capcnt3", 12'h004, 0, 32'd3, 2'b00, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mat_res_axil_reader.md
Name: mat_res_axil_reader

Overview:
Consumer end of the matrix multiplier result handshake. It accepts a completed result matrix on a valid/ready interface and holds it in a local buffer. It then serves the buffer and status words to the PS over an AXI4-Lite read-only slave. The buffer auto-releases when software reads the last element, which frees the multiplier for its next result.

Parameters:
DATA_WIDTH, 32, element width; also the AXI read data width (must be 32)
ROWS, 4, result matrix rows
COLS, 4, result matrix columns
ADDR_WIDTH, 12, AXI4-Lite byte address width

Ports:
clk  in  1  clock
rstn  in  1  reset; one clock; reset is asynchronous and active-low
c  in  DATA_WIDTH x [0:ROWS-1][0:COLS-1]  result matrix, stable while in_valid=1
in_valid  in  1  result matrix available (from multiplier out_valid)
in_ready  out  1  buffer can accept (to multiplier out_ready)
s_araddr  in  ADDR_WIDTH  read address (byte)
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
buf_full  out  1  buffer holds an unread result
cap_count  out  32  number of matrices captured

Behaviour:
- Reset (async, rstn=0): buf_full=0, buffer elements=0, cap_count=0, s_arready=0, s_rvalid=0, s_rdata=0, s_rresp=0. In this state in_ready=!buf_full=1.
- Release of rstn is synchronised to clk. All state is held at reset values until the first rising edge after rstn=1.
- Capture:
  - in_ready = !buf_full (combinational).
  - On an edge with in_valid & in_ready: buffer <= c, buf_full <= 1, cap_count <= cap_count+1 (wraps at 2^32).
  - No capture occurs while buf_full=1.
- Release:
  - An accepted AR to the last element (index ROWS*COLS-1) while buf_full=1 clears buf_full.
  - The clear happens on the R handshake edge (s_rvalid & s_rready).
  - in_ready rises the next cycle. Capture and release never coincide.
- Read FSM, IDLE (s_arready=1, s_rvalid=0):
  - On s_arvalid: latch the decoded data/resp into s_rdata/s_rresp.
  - Go to RESP; s_rvalid=1 from the next cycle.
- Read FSM, RESP (s_arready=0, s_rvalid=1):
  - s_rdata and s_rresp are held stable until s_rready.
  - On s_rready: return to IDLE, s_arready=1 the next cycle.
  - One outstanding read only; throughput is one read per 2 cycles minimum.
- Address decode: uses s_araddr[ADDR_WIDTH-1:2]; bits [1:0] are ignored.
  - 0x000 STATUS: bit0=buf_full, bit1=in_valid, others 0; resp OKAY (2'b00).
  - 0x004 CAP_COUNT: resp OKAY.
  - 0x100 + 4*(i*COLS+j), for i<ROWS and j<COLS: element c[i][j].
    - If buf_full=1: data = element, resp OKAY.
    - If buf_full=0: data 0, resp SLVERR (2'b10), no release.
  - Any other address: data 0, resp SLVERR.
- Data is sampled at the AR handshake edge. A capture in the same cycle is not visible to that read.
- Element reads may be in any order and repeated. Only a read of the last index releases the buffer.
- Reset mid-transaction: s_rvalid drops immediately, the in-flight read is lost, and the buffer is cleared.
- in_valid deasserting without a handshake has no effect.

Test Plan:
- Reset, then read 0x000 -> rdata=0x0, rresp=0; in_ready=1, cap_count=0.
- Present c[i][j]=i*4+j+1 with in_valid=1 for one edge -> buf_full=1 and in_ready=0 next cycle. Reads of 0x100, 0x114 and 0x138 -> 1, 6, 15, rresp=0. buf_full stays 1. Read 0x004 -> 1.
- Read 0x13C -> rdata=16, rresp=0. buf_full=0 and in_ready=1 on the cycle after the R handshake. A second read of 0x13C -> rdata=0, rresp=2'b10.
- Hold s_rready=0 for 5 cycles after an AR to 0x104 -> s_rvalid held, rdata=2 stable, s_arready=0 throughout. Release occurs only on handshake.
- Read 0x0FC and 0x200 -> rdata=0, rresp=2'b10. Read 0x103 -> same as 0x100 (low bits ignored).
- Assert rstn=0 mid-RESP with buffer full -> s_rvalid=0 and buf_full=0 asynchronously. After release, 3 back-to-back captures with full drains give cap_count=3.
